// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce generator and its LFSR.
package bounce_pkg;

  // Burst FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (stages 16,14,13,11 -> bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Substituted when a zero seed is requested; an all-zero LFSR would lock up
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every clock, reset to the supplied seed.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift left, feeding the XOR of the tapped stages into bit 0
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      q <= seed;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bounce_generator.sv
// Emulates a mechanically bouncing push-button: on each requested level change the output
// chatters with pseudo-random run lengths for a fixed window, then settles to the request.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 1000,
  parameter int unsigned MIN_HOLD      = 4,
  parameter int unsigned HOLD_BITS     = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       level_in,
  output logic       btn_out,
  output logic       busy,
  output logic       stable_level,
  output logic [7:0] toggle_count
);

  localparam logic [15:0] EFF_SEED    = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam logic [15:0] WINDOW_LOAD = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_MIN    = 16'(MIN_HOLD);
  localparam logic [15:0] HOLD_MASK   = 16'((32'd1 << HOLD_BITS) - 32'd1);

  logic [15:0] lfsr_q;
  logic [8:0]  hold_reload;

  state_e      state_q, state_d;
  logic [15:0] window_q, window_d;
  logic [8:0]  hold_q, hold_d;
  logic        btn_q, btn_d;
  logic        stable_q, stable_d;
  logic        busy_q, busy_d;
  logic [7:0]  count_q, count_d;

  lfsr16 u_lfsr (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .seed       (EFF_SEED),
    .q          (lfsr_q)
  );

  // Random hold: MIN_HOLD plus the low HOLD_BITS of the LFSR (mask is zero when HOLD_BITS==0)
  assign hold_reload = 9'(HOLD_MIN + (lfsr_q & HOLD_MASK));

  // Next-state logic for the burst FSM, window/hold counters and output levels
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    hold_d   = hold_q;
    btn_d    = btn_q;
    stable_d = stable_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        btn_d = stable_q;
        if (level_in != stable_q) begin
          state_d  = BOUNCE;
          window_d = WINDOW_LOAD;
          hold_d   = hold_reload;
          count_d  = 8'd0;
        end
      end
      BOUNCE: begin
        window_d = (window_q == 16'd0) ? 16'd0 : window_q - 16'd1;
        if (hold_q == 9'd0) begin
          btn_d  = ~btn_q;
          hold_d = hold_reload;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end else begin
          hold_d = hold_q - 9'd1;
        end
        // A toggle on the final window cycle still happens; SETTLE then overrides the level
        if (window_q == 16'd0) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        btn_d    = level_in;
        stable_d = level_in;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; all outputs come straight from flops
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= IDLE;
      window_q <= 16'd0;
      hold_q   <= 9'd0;
      btn_q    <= 1'b0;
      stable_q <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      hold_q   <= hold_d;
      btn_q    <= btn_d;
      stable_q <= stable_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign btn_out      = btn_q;
  assign busy         = busy_q;
  assign stable_level = stable_q;
  assign toggle_count = count_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench: three instances (default seed, seed 1, seed 0) share stimulus and are
// compared cycle by cycle against a toggle-schedule model of the bounce burst.
module tb_bounce_generator;

  localparam int unsigned BC = 20;
  localparam int unsigned MH = 2;
  localparam int unsigned HB = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       level_in = 1'b0;
  logic       btn, busy, stable;
  logic       btn1, busy1, stable1;
  logic       btn0, busy0, stable0;
  logic [7:0] tc, tc1, tc0;

  int   errors = 0;
  int   checks = 0;
  logic exp_stable = 1'b0;

  // Model LFSR values for seed ACE1 (also the seed-0 instance) and seed 0001
  logic [15:0] m_lfsr_a, m_lfsr_b;

  always #5 clk = ~clk;

  bounce_generator #(.BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .HOLD_BITS(HB)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .level_in(level_in), .btn_out(btn), .busy(busy),
    .stable_level(stable), .toggle_count(tc));

  bounce_generator #(.BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .HOLD_BITS(HB), .SEED(16'h0001)) dut_s1 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .level_in(level_in), .btn_out(btn1), .busy(busy1),
    .stable_level(stable1), .toggle_count(tc1));

  bounce_generator #(.BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .HOLD_BITS(HB), .SEED(16'h0000)) dut_s0 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .level_in(level_in), .btn_out(btn0), .busy(busy0),
    .stable_level(stable0), .toggle_count(tc0));

  // Polynomial x^16+x^14+x^13+x^11+1: new bit = stage16 ^ stage14 ^ stage13 ^ stage11
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lfsr_a <= 16'hACE1;
      m_lfsr_b <= 16'h0001;
    end else begin
      m_lfsr_a <= lfsr_next(m_lfsr_a);
      m_lfsr_b <= lfsr_next(m_lfsr_b);
    end
  end

  // Toggle schedule of one burst: tog[t]=1 means btn flips at edge E+t (E = burst-start edge).
  // Each hold draws MIN_HOLD + (lfsr mod 2^HOLD_BITS) from the LFSR value at the edge it starts.
  task automatic predict(input logic [15:0] x0, output logic [BC:0] tog);
    logic [15:0] lf [0:BC];
    int t, h;
    lf[0] = x0;
    for (int i = 1; i <= int'(BC); i++) lf[i] = lfsr_next(lf[i-1]);
    tog = '0;
    t = 0;
    h = int'(MH) + int'(lf[0] % (16'd1 << HB));
    while (1) begin
      t = t + h + 1;
      if (t > int'(BC)) break;
      tog[t] = 1'b1;
      h = int'(MH) + int'(lf[t] % (16'd1 << HB));
    end
  endtask

  // Request lvl at a negedge and follow the burst through SETTLE; optionally flip level_in
  // after the sample of cycle glitch_at (0..BC) to exercise mid-burst changes.
  task automatic run_burst(input logic lvl, input int glitch_at, input string tag);
    logic [BC:0] tog_a, tog_b;
    logic        start, ea, eb, fin, eb_busy;
    logic [7:0]  ca, cb;
    start = exp_stable;
    level_in = lvl;
    predict(m_lfsr_a, tog_a);
    predict(m_lfsr_b, tog_b);
    ea = start; eb = start; fin = lvl; ca = 8'd0; cb = 8'd0;
    for (int i = 0; i <= int'(BC) + 1; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= int'(BC)) begin
        if (tog_a[i]) begin ea = ~ea; ca = ca + 8'd1; end
        if (tog_b[i]) begin eb = ~eb; cb = cb + 8'd1; end
      end
      if (i == int'(BC) + 1) begin ea = fin; eb = fin; end
      eb_busy = (i <= int'(BC));
      checks++;
      if ({busy, busy1, busy0} !== {3{eb_busy}}) begin
        errors++;
        $display("FAIL %s busy cyc%0d: got %b%b%b want %b", tag, i, busy, busy1, busy0, eb_busy);
      end
      checks++;
      if ({btn, btn0, btn1} !== {ea, ea, eb}) begin
        errors++;
        $display("FAIL %s btn_out cyc%0d: got %b%b%b want %b%b%b", tag, i, btn, btn0, btn1,
                 ea, ea, eb);
      end
      checks++;
      if ({stable, stable1, stable0} !== {3{(i <= int'(BC)) ? start : fin}}) begin
        errors++;
        $display("FAIL %s stable_level cyc%0d: got %b%b%b", tag, i, stable, stable1, stable0);
      end
      checks++;
      if (tc !== ca || tc0 !== ca || tc1 !== cb) begin
        errors++;
        $display("FAIL %s toggle_count cyc%0d: got %0d/%0d/%0d want %0d/%0d/%0d", tag, i,
                 tc, tc0, tc1, ca, ca, cb);
      end
      if (i == glitch_at) level_in = ~level_in;
      if (i <= int'(BC)) fin = level_in;
    end
    checks++;
    if (tc < 8'd3 || tc > 8'd7) begin
      errors++;
      $display("FAIL %s toggle_count range: got %0d want 3..7", tag, tc);
    end
    exp_stable = fin;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, busy1, busy0} !== 3'b000) begin
        errors++;
        $display("FAIL %s idle busy: got %b%b%b want 000", tag, busy, busy1, busy0);
      end
      checks++;
      if ({btn, btn1, btn0, stable, stable1, stable0} !== {6{exp_stable}}) begin
        errors++;
        $display("FAIL %s idle levels: got btn %b%b%b stable %b%b%b want %b", tag, btn, btn1,
                 btn0, stable, stable1, stable0, exp_stable);
      end
    end
  endtask

  task automatic check_zeroed(input string tag);
    checks++;
    if ({btn, btn1, btn0, busy, busy1, busy0, stable, stable1, stable0} !== 9'd0 ||
        tc !== 8'd0 || tc1 !== 8'd0 || tc0 !== 8'd0) begin
      errors++;
      $display("FAIL %s reset values: got btn %b%b%b busy %b%b%b stable %b%b%b tc %0d/%0d/%0d",
               tag, btn, btn1, btn0, busy, busy1, busy0, stable, stable1, stable0, tc, tc1, tc0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    level_in = 1'b0;
    #1;
    check_zeroed("reset_async");
    repeat (3) begin
      @(negedge clk);
      check_zeroed("reset_held");
    end
    rstn = 1'b1;
    exp_stable = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rstn = 1'b0;
    #1;
    check_zeroed("reset_initial");
    repeat (3) begin
      @(negedge clk);
      check_zeroed("reset_held");
    end
    rstn = 1'b1;
    exp_stable = 1'b0;
    idle_cycles(10, "reset_idle");
  endtask

  task automatic test_rising_press();
    run_burst(1'b1, -1, "rise");
    idle_cycles(3, "rise_after");
  endtask

  task automatic test_release();
    run_burst(1'b0, -1, "release");
    idle_cycles(3, "release_after");
  endtask

  task automatic test_glitch();
    run_burst(1'b1, 10, "glitch");
    checks++;
    if (exp_stable !== 1'b0 || btn !== 1'b0) begin
      errors++;
      $display("FAIL glitch final: got btn %b want 0", btn);
    end
    idle_cycles(3, "glitch_after");
  endtask

  task automatic test_back_to_back();
    run_burst(~exp_stable, -1, "b2b_first");
    run_burst(~exp_stable, -1, "b2b_second");
    idle_cycles(2, "b2b_after");
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 12; n++) begin
      idle_cycles(int'($urandom_range(0, 4)), "rand_gap");
      g = int'($urandom_range(0, 40));
      run_burst(~exp_stable, (g <= int'(BC)) ? g : -1, "rand");
    end
    idle_cycles(2, "rand_after");
  endtask

  task automatic test_midburst_reset();
    if (exp_stable) run_burst(1'b0, -1, "mid_prep");
    level_in = 1'b1;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset pre busy: got %b want 1", busy);
    end
    rstn = 1'b0;
    #1;
    check_zeroed("mid_reset_async");
    repeat (2) begin
      @(negedge clk);
      check_zeroed("mid_reset_held");
    end
    rstn = 1'b1;
    exp_stable = 1'b0;
    run_burst(1'b1, -1, "mid_reset_restart");
    idle_cycles(2, "mid_reset_after");
  endtask

  // Two fresh-from-reset bursts; each is checked against the seed models for every instance
  task automatic test_determinism();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      run_burst(1'b1, -1, "determinism");
      idle_cycles(2, "determinism_after");
    end
  endtask

  initial begin
    test_reset();
    test_rising_press();
    test_release();
    test_glitch();
    test_back_to_back();
    test_random();
    test_midburst_reset();
    test_determinism();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
